// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBeq    = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct field to ALU operation; flags functs the datapath cannot execute.
module alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [2:0] o_alucontrol,
  output logic       o_funct_illegal
);

  always_comb begin
    o_alucontrol    = AluAdd;
    o_funct_illegal = 1'b0;
    case (i_funct)
      FunctAdd: o_alucontrol = AluAdd;
      FunctSub: o_alucontrol = AluSub;
      FunctAnd: o_alucontrol = AluAnd;
      FunctOr:  o_alucontrol = AluOr;
      FunctSlt: o_alucontrol = AluSlt;
      default:  o_funct_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences the shared ALU and unified memory port
// over several cycles per instruction and drives all datapath selects/strobes.
module multicycle_controller
  import mips_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alucontrol,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     r_state;
  state_e     w_next_state;
  logic [2:0] w_dec_alucontrol;
  logic       w_funct_illegal;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_pc_en;
  logic       w_instr_done;
  logic       w_illegal;

  alu_decoder u_alu_decoder (
    .i_funct         (funct),
    .o_alucontrol    (w_dec_alucontrol),
    .o_funct_illegal (w_funct_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StFetch;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = StFetch;
    case (r_state)
      StFetch:  w_next_state = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OpLw, OpSw: w_next_state = StMemAdr;
          OpRtype:    w_next_state = StExec;
          OpBeq:      w_next_state = StBeq;
          OpAddi:     w_next_state = StAddiEx;
          OpJ:        w_next_state = StJump;
          default:    w_next_state = StFetch;
        endcase
      end
      StMemAdr: w_next_state = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd:  w_next_state = mem_ready ? StMemWb : StMemRd;
      StMemWr:  w_next_state = mem_ready ? StFetch : StMemWr;
      StExec:   w_next_state = w_funct_illegal ? StFetch : StAluWb;
      StAddiEx: w_next_state = StAddiWb;
      default:  w_next_state = StFetch;
    endcase
  end

  always_comb begin
    iord         = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    w_reg_write  = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SrcBReg;
    alucontrol   = AluAdd;
    pc_src       = PcSrcAlu;
    w_pc_en      = 1'b0;
    w_instr_done = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      StFetch: begin
        alu_src_b  = SrcBFour;
        w_ir_write = mem_ready;
        w_pc_en    = mem_ready;
      end
      StDecode: begin
        alu_src_b = SrcBImmSh;
        case (opcode)
          OpLw, OpSw, OpRtype, OpBeq, OpAddi, OpJ: w_illegal = 1'b0;
          default:                                 w_illegal = 1'b1;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
      end
      StMemRd: iord = 1'b1;
      StMemWb: begin
        mem_to_reg   = 1'b1;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      StMemWr: begin
        iord         = 1'b1;
        w_mem_write  = 1'b1;
        w_instr_done = mem_ready;
      end
      StExec: begin
        alu_src_a  = 1'b1;
        alucontrol = w_dec_alucontrol;
        w_illegal  = w_funct_illegal;
      end
      StAluWb: begin
        reg_dst      = 1'b1;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      StBeq: begin
        alu_src_a    = 1'b1;
        alucontrol   = AluSub;
        pc_src       = PcSrcAluOut;
        w_pc_en      = zero;
        w_instr_done = 1'b1;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
      end
      StAddiWb: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      StJump: begin
        pc_src       = PcSrcJump;
        w_pc_en      = 1'b1;
        w_instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // State is already FETCH during reset, but FETCH strobes follow mem_ready,
  // so every strobe is masked while rst_n is low.
  assign ir_write   = w_ir_write & rst_n;
  assign mem_write  = w_mem_write & rst_n;
  assign reg_write  = w_reg_write & rst_n;
  assign pc_en      = w_pc_en & rst_n;
  assign instr_done = w_instr_done & rst_n;
  assign illegal    = w_illegal & rst_n;
  assign state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios plus random
// instructions checked against an instruction-level latency/strobe-count model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       iord, ir_write, mem_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alucontrol;
  logic       pc_en, instr_done, illegal;
  logic [3:0] state;

  int n_pass = 0;
  int n_total = 0;

  logic [3:0] st_a[32];
  logic       pe_a[32];
  logic       mw_a[32];
  logic       rw_a[32];

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alucontrol (alucontrol),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // {legal, alu code} for an R-type funct
  function automatic logic [3:0] ref_funct(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b1_010;
      6'b100010: return 4'b1_110;
      6'b100100: return 4'b1_000;
      6'b100101: return 4'b1_001;
      6'b101010: return 4'b1_111;
      default:   return 4'b0_010;
    endcase
  endfunction

  // Runs one instruction starting in FETCH: fw fetch wait cycles, mw memory wait cycles.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    int len, e_rw, e_mwr, e_done, e_ill, e_pe, e_irw;
    int c_rw, c_mwr, c_done, c_ill, c_pe, c_irw;
    logic e_dst, e_m2r, wb_dst, wb_m2r, is_mem, r_legal;
    logic [1:0] last_pcsrc;
    logic [2:0] last_alu, alu_seen;
    logic [3:0] fdec;
    fdec = ref_funct(fn);
    r_legal = (op == 6'b000000) && fdec[3];
    is_mem = 1'b0; e_rw = 0; e_mwr = 0; e_done = 1; e_ill = 0; e_pe = 1; e_irw = 1;
    e_dst = 1'b0; e_m2r = 1'b0;
    c_rw = 0; c_mwr = 0; c_done = 0; c_ill = 0; c_pe = 0; c_irw = 0;
    wb_dst = 1'bx; wb_m2r = 1'bx; alu_seen = 3'bxxx; last_pcsrc = 2'bxx; last_alu = 3'bxxx;
    case (op)
      6'b100011: begin len = fw + 5 + mw; e_rw = 1; e_m2r = 1'b1; is_mem = 1'b1; end
      6'b101011: begin len = fw + 4 + mw; e_mwr = mw + 1; is_mem = 1'b1; end
      6'b000000: begin
        if (r_legal) begin len = fw + 4; e_rw = 1; e_dst = 1'b1; end
        else begin len = fw + 3; e_done = 0; e_ill = 1; end
      end
      6'b001000: begin len = fw + 4; e_rw = 1; end
      6'b000100: begin len = fw + 3; e_pe = 1 + int'(z); end
      6'b000010: begin len = fw + 3; e_pe = 2; end
      default:   begin len = fw + 2; e_done = 0; e_ill = 1; end
    endcase
    for (int k = 0; k < len; k++) begin
      @(posedge clk);
      #1;
      opcode = op; funct = fn; zero = z;
      if (k < fw) mem_ready = 1'b0;
      else if (k == fw) mem_ready = 1'b1;
      else if (is_mem && k >= fw + 3 && k < fw + 3 + mw) mem_ready = 1'b0;
      else if (is_mem && k == fw + 3 + mw) mem_ready = 1'b1;
      else mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      st_a[k] = state; pe_a[k] = pc_en; mw_a[k] = mem_write; rw_a[k] = reg_write;
      if (reg_write === 1'b1) begin c_rw++; wb_dst = reg_dst; wb_m2r = mem_to_reg; end
      if (mem_write === 1'b1) c_mwr++;
      if (instr_done === 1'b1) c_done++;
      if (illegal === 1'b1) c_ill++;
      if (pc_en === 1'b1) c_pe++;
      if (ir_write === 1'b1) c_irw++;
      if (k == fw + 2) alu_seen = alucontrol;
      if (k == len - 1) begin last_pcsrc = pc_src; last_alu = alucontrol; end
    end
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    check("end_in_fetch", {28'd0, state}, 32'd0);
    check("reg_write_cycles", c_rw, e_rw);
    check("mem_write_cycles", c_mwr, e_mwr);
    check("instr_done_pulses", c_done, e_done);
    check("illegal_pulses", c_ill, e_ill);
    check("pc_en_cycles", c_pe, e_pe);
    check("ir_write_cycles", c_irw, e_irw);
    if (e_rw == 1) begin
      check("wb_reg_dst", {31'd0, wb_dst}, {31'd0, e_dst});
      check("wb_mem_to_reg", {31'd0, wb_m2r}, {31'd0, e_m2r});
    end
    if (r_legal) check("exec_alucontrol", {29'd0, alu_seen}, {29'd0, fdec[2:0]});
    if (op == 6'b000100) begin
      check("beq_pc_src", {30'd0, last_pcsrc}, 32'd1);
      check("beq_alucontrol", {29'd0, last_alu}, 32'd6);
    end
    if (op == 6'b000010) check("j_pc_src", {30'd0, last_pcsrc}, 32'd2);
  endtask

  initial begin
    logic [5:0] ops[8];
    logic [5:0] fns[6];
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100, 6'b001000, 6'b000010,
            6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

    // Reset with mem_ready high: strobes must stay quiet, selects at FETCH values
    mem_ready = 1'b1;
    opcode = 6'b111111;
    #12;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_ir_write", {31'd0, ir_write}, 32'd0);
    check("rst_pc_en", {31'd0, pc_en}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_alu_src_b", {30'd0, alu_src_b}, 32'd1);
    check("rst_iord", {31'd0, iord}, 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    // lw with no waits: states 0..4, writeback only in state 4
    run_instr(6'b100011, 6'd0, 1'b0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      check("lw_state_seq", {28'd0, st_a[k]}, k);
      check("lw_rw_only_wb", {31'd0, rw_a[k]}, {31'd0, k == 4});
    end

    // sw with 3 memory waits: mem_write held 4 cycles in MEMWR
    run_instr(6'b101011, 6'd0, 1'b0, 0, 3);
    check("sw_no_early_write", {31'd0, mw_a[2]}, 32'd0);
    for (int k = 3; k < 7; k++) begin
      check("sw_memwr_state", {28'd0, st_a[k]}, 32'd5);
      check("sw_mem_write", {31'd0, mw_a[k]}, 32'd1);
    end

    // beq taken then not taken
    run_instr(6'b000100, 6'd0, 1'b1, 0, 0);
    check("beq_taken_state", {28'd0, st_a[2]}, 32'd8);
    check("beq_taken_pc_en", {31'd0, pe_a[2]}, 32'd1);
    run_instr(6'b000100, 6'd0, 1'b0, 0, 0);
    check("beq_not_taken_pc_en", {31'd0, pe_a[2]}, 32'd0);

    // slt, then an undefined funct
    run_instr(6'b000000, 6'b101010, 1'b0, 0, 0);
    run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);
    check("bad_funct_in_exec", {28'd0, st_a[2]}, 32'd6);

    // Illegal opcode after a 2-cycle fetch stall
    run_instr(6'b111111, 6'd0, 1'b0, 2, 0);
    check("stall_pc_en_0", {31'd0, pe_a[0]}, 32'd0);
    check("stall_pc_en_1", {31'd0, pe_a[1]}, 32'd0);
    check("stall_pc_en_rise", {31'd0, pe_a[2]}, 32'd1);
    check("illegal_in_decode", {28'd0, st_a[3]}, 32'd1);

    run_instr(6'b001000, 6'd0, 1'b0, 1, 0);
    run_instr(6'b000010, 6'd0, 1'b0, 0, 0);

    // Reset asserted while waiting in MEMRD with mem_ready high
    @(posedge clk);
    #1 opcode = 6'b100011; mem_ready = 1'b1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_memrd", {28'd0, state}, 32'd3);
    #2 mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_state", {28'd0, state}, 32'd0);
    check("midrst_reg_write", {31'd0, reg_write}, 32'd0);
    check("midrst_ir_write", {31'd0, ir_write}, 32'd0);
    check("midrst_pc_en", {31'd0, pc_en}, 32'd0);
    check("midrst_instr_done", {31'd0, instr_done}, 32'd0);
    @(posedge clk);
    #1;
    check("midrst_hold", {28'd0, state}, 32'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Random instruction mix with random fetch/memory waits and branch flags
    for (int i = 0; i < 60; i++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 7)];
      fn = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom);
      if (op == 6'b111111 && $urandom_range(0, 1) == 1) op = 6'($urandom_range(16, 31));
      run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
